spi_burst_ram: RTL and testbench

SPI_BURST_RAM -- requirements
Module: spi_burst_ram

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_burst_ram_if.sv | 30 +++
 rtl/spi_ram_mem.sv | 44 ++++
 rtl/spi_burst_ram.sv | 140 ++++++++++++++
 tb/tb_spi_burst_ram.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI burst RAM slice.
//   cmd_e   : 2-bit command field carried in din[DATA_W+1:DATA_W]
//   state_e : controller state (IDLE accepts commands, XFER streams a burst)
// -----------------------------------------------------------------------------
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WADDR = 2'b00,  // load write address
        CMD_WDATA = 2'b01,  // write payload at write address
        CMD_RADDR = 2'b10,  // load read address
        CMD_READ  = 2'b11   // burst read of payload+1 words
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

endpackage

// File: rtl/spi_burst_ram_if.sv
// -----------------------------------------------------------------------------
// spi_burst_ram_if
// Command/response bus of the SPI burst RAM.
//   din      : {command[1:0], payload[DATA_W-1:0]}
//   rx_valid : din valid            rx_ready : block accepts a command
//   dout     : read data word       tx_valid : dout valid, held until taken
//   tx_ready : consumer takes dout  cmd_err  : one-cycle dropped-command pulse
// Modports: slave = the RAM block, master = the command source / consumer.
// -----------------------------------------------------------------------------
interface spi_burst_ram_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              tx_ready;
    logic              cmd_err;

    modport slave (
        input  din, rx_valid, tx_ready,
        output rx_ready, dout, tx_valid, cmd_err
    );

    modport master (
        output din, rx_valid, tx_ready,
        input  rx_ready, dout, tx_valid, cmd_err
    );
endinterface

// File: rtl/spi_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_ram_mem
// Single-port RAM, synchronous write and synchronous read.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   i_we       : write i_wdata to mem[i_addr] at this edge
//   i_re       : load o_rdata from mem[i_addr] at this edge, otherwise hold
//   i_addr     : shared read/write address
//   o_rdata    : registered read data (cleared by reset, array is not)
// -----------------------------------------------------------------------------
module spi_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // The read register doubles as the output word, so it holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/spi_burst_ram.sv
// -----------------------------------------------------------------------------
// spi_burst_ram
// Command-driven RAM: set write address, write words (optionally auto-
// incrementing), set read address, and stream bursts of payload+1 words
// with a valid/ready handshake on the output side.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (RAM contents survive)
//   bus   : spi_burst_ram_if.slave (din/rx_valid/rx_ready, dout/tx_valid/
//           tx_ready, cmd_err)
// Parameters: DATA_W word width, ADDR_W address width (<= DATA_W),
//             AUTO_INC 1 = write address advances after each write.
// -----------------------------------------------------------------------------
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int AUTO_INC = 1
) (
    input logic            clk,
    input logic            rst_n,
    spi_burst_ram_if.slave bus
);
    if (ADDR_W > DATA_W) begin : g_param_check
        $error("spi_burst_ram: ADDR_W must not exceed DATA_W");
    end

    state_e            r_state;
    state_e            w_state_nx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] w_wr_addr_nx;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr_nx;
    logic [DATA_W-1:0] r_remaining;
    logic [DATA_W-1:0] w_remaining_nx;
    logic              r_tx_valid;
    logic              w_tx_valid_nx;
    logic              r_cmd_err;
    logic              w_rx_ready;
    logic              w_accept;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_payload;
    logic [DATA_W-1:0] w_rdata;
    cmd_e              w_cmd;

    assign w_cmd      = cmd_e'(bus.din[DATA_W+1:DATA_W]);
    assign w_payload  = bus.din[DATA_W-1:0];
    assign w_rx_ready = (r_state == ST_IDLE);
    assign w_accept   = bus.rx_valid && w_rx_ready;

    // Next-state and datapath control. Writes only happen in IDLE and reads
    // only on burst start or inside XFER, so one RAM port is enough.
    always_comb begin
        w_state_nx     = r_state;
        w_wr_addr_nx   = r_wr_addr;
        w_rd_addr_nx   = r_rd_addr;
        w_remaining_nx = r_remaining;
        w_tx_valid_nx  = r_tx_valid;
        w_mem_we       = 1'b0;
        w_mem_re       = 1'b0;
        w_mem_addr     = r_rd_addr;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_cmd)
                        CMD_WADDR: w_wr_addr_nx = w_payload[ADDR_W-1:0];
                        CMD_WDATA: begin
                            w_mem_we   = 1'b1;
                            w_mem_addr = r_wr_addr;
                            if (AUTO_INC != 0) begin
                                w_wr_addr_nx = r_wr_addr + 1'b1;
                            end
                        end
                        CMD_RADDR: w_rd_addr_nx = w_payload[ADDR_W-1:0];
                        CMD_READ: begin
                            w_mem_re       = 1'b1;
                            w_rd_addr_nx   = r_rd_addr + 1'b1;
                            w_remaining_nx = w_payload;
                            w_tx_valid_nx  = 1'b1;
                            w_state_nx     = ST_XFER;
                        end
                    endcase
                end
            end
            ST_XFER: begin
                // tx_valid is always high here; a handshake either fetches the
                // next word in the same edge or closes the burst.
                if (bus.tx_ready) begin
                    if (r_remaining != '0) begin
                        w_mem_re       = 1'b1;
                        w_rd_addr_nx   = r_rd_addr + 1'b1;
                        w_remaining_nx = r_remaining - 1'b1;
                    end else begin
                        w_tx_valid_nx = 1'b0;
                        w_state_nx    = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_tx_valid  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_wr_addr   <= w_wr_addr_nx;
            r_rd_addr   <= w_rd_addr_nx;
            r_remaining <= w_remaining_nx;
            r_tx_valid  <= w_tx_valid_nx;
            r_cmd_err   <= bus.rx_valid && !w_rx_ready;
        end
    end

    spi_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_payload),
        .o_rdata (w_rdata)
    );

    assign bus.rx_ready = w_rx_ready;
    assign bus.dout     = w_rdata;
    assign bus.tx_valid = r_tx_valid;
    assign bus.cmd_err  = r_cmd_err;
endmodule

// File: tb/tb_spi_burst_ram.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_ram
// Self-checking bench for spi_burst_ram (DATA_W=8, ADDR_W=8, AUTO_INC=1).
// A reference model (plain array plus two address variables) tracks what the
// RAM should hold and where reads continue from.
// -----------------------------------------------------------------------------
module tb_spi_burst_ram;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_burst_ram_if #(.DATA_W(8)) bus ();

    spi_burst_ram #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .AUTO_INC (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [7:0] m_mem [256];
    logic [7:0] m_wr;
    logic [7:0] m_rd;

    // Present one command for one cycle while the block is idle and apply
    // its effect to the model.
    task automatic send(input logic [1:0] cmd, input logic [7:0] pl);
        @(negedge clk);
        bus.din      = {cmd, pl};
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        case (cmd)
            2'b00: m_wr = pl;
            2'b01: begin
                m_mem[m_wr] = pl;
                m_wr        = m_wr + 8'd1;
            end
            2'b10: m_rd = pl;
            default: ;
        endcase
    endtask

    // Burst of n words from the model's read address; word stall_at gets
    // stall_len extra cycles with tx_ready low, others get 0..2 if rnd.
    task automatic do_burst(input int n, input int stall_at, input int stall_len, input bit rnd);
        logic [7:0] a;
        logic [7:0] exp;
        int         st;
        a            = m_rd;
        bus.tx_ready = 1'b0;
        send(2'b11, 8'(n - 1));
        for (int k = 0; k < n; k++) begin
            exp = m_mem[a];
            st  = (k == stall_at) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < st; s++) begin
                n_vec++;
                if (bus.tx_valid !== 1'b1 || bus.dout !== exp || bus.rx_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL burst_hold k=%0d s=%0d: got vld=%b dout=%h rdy=%b, want vld=1 dout=%h rdy=0",
                             k, s, bus.tx_valid, bus.dout, bus.rx_ready, exp);
                end
                @(negedge clk);
            end
            n_vec++;
            if (bus.tx_valid !== 1'b1 || bus.dout !== exp || bus.rx_ready !== 1'b0) begin
                n_err++;
                $display("FAIL burst_word k=%0d addr=%h: got vld=%b dout=%h rdy=%b, want vld=1 dout=%h rdy=0",
                         k, a, bus.tx_valid, bus.dout, bus.rx_ready, exp);
            end
            bus.tx_ready = 1'b1;
            @(negedge clk);
            bus.tx_ready = 1'b0;
            a = a + 8'd1;
        end
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1 || bus.cmd_err !== 1'b0) begin
            n_err++;
            $display("FAIL burst_end: got vld=%b rdy=%b err=%b, want vld=0 rdy=1 err=0",
                     bus.tx_valid, bus.rx_ready, bus.cmd_err);
        end
        m_rd = a;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        bus.din      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_wr  = 8'h00;
        m_rd  = 8'h00;
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.dout !== 8'h00 || bus.rx_ready !== 1'b1 || bus.cmd_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got vld=%b dout=%h rdy=%b err=%b, want vld=0 dout=00 rdy=1 err=0",
                     bus.tx_valid, bus.dout, bus.rx_ready, bus.cmd_err);
        end
    endtask

    // Give every RAM location a known random value via auto-increment writes.
    task automatic test_fill();
        send(2'b00, 8'h00);
        for (int i = 0; i < 256; i++) send(2'b01, 8'($urandom));
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.dout !== 8'h00) begin
            n_err++;
            $display("FAIL fill_no_tx: got vld=%b dout=%h, want vld=0 dout=00", bus.tx_valid, bus.dout);
        end
    endtask

    task automatic test_basic();
        send(2'b00, 8'h10);
        send(2'b01, 8'hAA);
        send(2'b01, 8'hBB);
        send(2'b10, 8'h10);
        bus.tx_ready = 1'b1;
        send(2'b11, 8'h01);
        n_vec++;
        if (bus.tx_valid !== 1'b1 || bus.dout !== 8'hAA) begin
            n_err++;
            $display("FAIL basic_word0: got vld=%b dout=%h, want vld=1 dout=aa", bus.tx_valid, bus.dout);
        end
        @(negedge clk);
        n_vec++;
        if (bus.tx_valid !== 1'b1 || bus.dout !== 8'hBB) begin
            n_err++;
            $display("FAIL basic_word1: got vld=%b dout=%h, want vld=1 dout=bb", bus.tx_valid, bus.dout);
        end
        @(negedge clk);
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_end: got vld=%b rdy=%b, want vld=0 rdy=1", bus.tx_valid, bus.rx_ready);
        end
        bus.tx_ready = 1'b0;
        m_rd = 8'h12;
        // Non-read commands leave the output word alone.
        send(2'b00, 8'h77);
        send(2'b10, 8'h12);
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.dout !== 8'hBB) begin
            n_err++;
            $display("FAIL basic_dout_hold: got vld=%b dout=%h, want vld=0 dout=bb", bus.tx_valid, bus.dout);
        end
    endtask

    task automatic test_stall();
        send(2'b00, 8'h20);
        for (int i = 0; i < 4; i++) send(2'b01, 8'($urandom));
        send(2'b10, 8'h20);
        do_burst(4, 1, 3, 1'b0);
        n_vec++;
        if (m_rd !== 8'h24) begin
            n_err++;
            $display("FAIL stall_model_addr: got %h, want 24", m_rd);
        end
    endtask

    task automatic test_wrap();
        send(2'b00, 8'hFF);
        send(2'b01, 8'h5A);
        send(2'b01, 8'h6B);
        send(2'b10, 8'hFF);
        do_burst(2, -1, 0, 1'b1);
        // Sequential continuation: the next burst starts at 0x01.
        do_burst(3, -1, 0, 1'b1);
        // Longer burst across the top of the address space with random stalls.
        send(2'b10, 8'hFA);
        do_burst(10, -1, 0, 1'b1);
    endtask

    task automatic test_cmd_err();
        logic [7:0] a;
        logic [7:0] v;
        send(2'b00, 8'h40);
        for (int i = 0; i < 3; i++) send(2'b01, 8'($urandom));
        send(2'b10, 8'h40);
        a            = 8'h40;
        bus.tx_ready = 1'b0;
        send(2'b11, 8'd2);
        // Command presented mid-burst must be dropped.
        bus.din      = {2'b00, 8'h33};
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        n_vec++;
        if (bus.cmd_err !== 1'b1 || bus.tx_valid !== 1'b1 || bus.dout !== m_mem[a]) begin
            n_err++;
            $display("FAIL cmd_err_pulse: got err=%b vld=%b dout=%h, want err=1 vld=1 dout=%h",
                     bus.cmd_err, bus.tx_valid, bus.dout, m_mem[a]);
        end
        @(negedge clk);
        n_vec++;
        if (bus.cmd_err !== 1'b0) begin
            n_err++;
            $display("FAIL cmd_err_one_cycle: got err=%b, want 0", bus.cmd_err);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (bus.tx_valid !== 1'b1 || bus.dout !== m_mem[a]) begin
                n_err++;
                $display("FAIL cmd_err_burst k=%0d: got vld=%b dout=%h, want vld=1 dout=%h",
                         k, bus.tx_valid, bus.dout, m_mem[a]);
            end
            bus.tx_ready = 1'b1;
            @(negedge clk);
            bus.tx_ready = 1'b0;
            a = a + 8'd1;
        end
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_err_end: got vld=%b rdy=%b, want vld=0 rdy=1", bus.tx_valid, bus.rx_ready);
        end
        m_rd = a;
        // Write address must still be 0x43; pick a value differing from old contents.
        v = ~m_mem[m_wr];
        send(2'b01, v);
        send(2'b10, 8'h43);
        do_burst(1, -1, 0, 1'b0);
        send(2'b10, 8'h33);
        do_burst(1, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        send(2'b00, 8'h80);
        for (int i = 0; i < 4; i++) send(2'b01, 8'($urandom));
        send(2'b10, 8'h80);
        bus.tx_ready = 1'b0;
        send(2'b11, 8'd3);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        n_vec++;
        if (bus.tx_valid !== 1'b1 || bus.dout !== m_mem[8'h81]) begin
            n_err++;
            $display("FAIL rst_mid_word1: got vld=%b dout=%h, want vld=1 dout=%h",
                     bus.tx_valid, bus.dout, m_mem[8'h81]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_wr  = 8'h00;
        m_rd  = 8'h00;
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1 || bus.dout !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_after: got vld=%b rdy=%b dout=%h, want vld=0 rdy=1 dout=00",
                     bus.tx_valid, bus.rx_ready, bus.dout);
        end
        @(negedge clk);
        n_vec++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_idle: got vld=%b rdy=%b, want vld=0 rdy=1", bus.tx_valid, bus.rx_ready);
        end
        // Read address was cleared: a burst without 10 starts at 0x00.
        do_burst(2, -1, 0, 1'b0);
        send(2'b10, 8'h80);
        do_burst(4, -1, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    send(2'b00, 8'($urandom));
                    for (int i = 0; i < int'($urandom_range(1, 5)); i++) send(2'b01, 8'($urandom));
                end
                1: send(2'b10, 8'($urandom));
                default: do_burst(int'($urandom_range(1, 8)), -1, 0, 1'b1);
            endcase
        end
        do_burst(int'($urandom_range(1, 8)), -1, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_stall();
        test_wrap();
        test_cmd_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running, want finished");
        $fatal(1, "timeout");
    end
endmodule
